// File: rtl/wb_sram_slave.sv
// ---------------------------------------------------------------------------
// wb_sram_slave
//
// Wishbone classic-cycle slave in front of an external 16-bit asynchronous
// SRAM. Each memory cycle from the bus master becomes exactly one SRAM access:
//
//   IDLE -> SETUP -> ACCESS (WAIT_STATES+1 cycles) -> ACK -> HOLD -> IDLE
//
// Every pin toward the SRAM and toward the master is driven from a flop, so
// no combinational path exists from wb_* inputs to the pads or to the ack.
// Strobe values are computed on the edge that enters a state, so the value
// seen on a pin during a cycle is the one that belongs to that state.
//
// Parameters
//   AW           SRAM word-address width; wb_adr_i[AW:1] is used, higher
//                address bits alias.
//   WAIT_STATES  extra SRAM access cycles (0..15).
//
// Ports
//   wb_clk_i      clock, all state on the rising edge
//   wb_rst_i      asynchronous reset, active low
//   wb_dat_i      write data from the master
//   wb_dat_o      registered read data to the master
//   wb_adr_i      word address [19:1]
//   wb_we_i       1 = write
//   wb_tga_i      1 = I/O cycle; such cycles are never answered
//   wb_sel_i      byte selects, [1] = high byte, [0] = low byte
//   wb_stb_i      strobe
//   wb_cyc_i      cycle; dropping it during SETUP/ACCESS aborts the access
//   wb_ack_o      one-cycle registered acknowledge
//   sram_addr_o   SRAM word address
//   sram_dat_i    SRAM DQ pad input
//   sram_dat_o    SRAM DQ pad output
//   sram_dq_oe_o  DQ pad output enable, 1 = drive
//   sram_ce_n_o   chip enable, active low
//   sram_oe_n_o   output enable, active low
//   sram_we_n_o   write enable, active low
//   sram_bhe_n_o  high-byte enable, active low
//   sram_ble_n_o  low-byte enable, active low
// ---------------------------------------------------------------------------
module wb_sram_slave #(
    parameter int AW          = 18,
    parameter int WAIT_STATES = 1
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [15:0]   wb_dat_i,
    output logic [15:0]   wb_dat_o,
    input  logic [19:1]   wb_adr_i,
    input  logic          wb_we_i,
    input  logic          wb_tga_i,
    input  logic [1:0]    wb_sel_i,
    input  logic          wb_stb_i,
    input  logic          wb_cyc_i,
    output logic          wb_ack_o,
    output logic [AW-1:0] sram_addr_o,
    input  logic [15:0]   sram_dat_i,
    output logic [15:0]   sram_dat_o,
    output logic          sram_dq_oe_o,
    output logic          sram_ce_n_o,
    output logic          sram_oe_n_o,
    output logic          sram_we_n_o,
    output logic          sram_bhe_n_o,
    output logic          sram_ble_n_o
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_ACCESS = 3'd2;
    localparam logic [2:0] ST_ACK    = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    logic [2:0] state;
    logic [3:0] wait_cnt;
    logic       we_r;       // latched direction of the current cycle
    logic       sel_any_r;  // at least one byte lane selected

    logic       req;
    logic       sel_any;

    // Address bits above AW alias; fold them so they are visibly consumed.
    logic       unused_adr;
    assign unused_adr = ^wb_adr_i;

    assign req     = wb_cyc_i & wb_stb_i & ~wb_tga_i;
    assign sel_any = |wb_sel_i;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state        <= ST_IDLE;
            wait_cnt     <= 4'd0;
            we_r         <= 1'b0;
            sel_any_r    <= 1'b0;
            wb_ack_o     <= 1'b0;
            wb_dat_o     <= 16'h0000;
            sram_addr_o  <= '0;
            sram_dat_o   <= 16'h0000;
            sram_dq_oe_o <= 1'b0;
            sram_ce_n_o  <= 1'b1;
            sram_oe_n_o  <= 1'b1;
            sram_we_n_o  <= 1'b1;
            sram_bhe_n_o <= 1'b1;
            sram_ble_n_o <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        sram_addr_o  <= wb_adr_i[AW:1];
                        sram_dat_o   <= wb_dat_i;
                        we_r         <= wb_we_i;
                        sel_any_r    <= sel_any;
                        // An empty byte select runs the full handshake but
                        // never touches the chip.
                        sram_ce_n_o  <= ~sel_any;
                        sram_bhe_n_o <= ~wb_sel_i[1];
                        sram_ble_n_o <= ~wb_sel_i[0];
                        sram_oe_n_o  <= wb_we_i | ~sel_any;
                        sram_we_n_o  <= 1'b1;
                        // Data is on the pads a full cycle before we_n falls.
                        sram_dq_oe_o <= wb_we_i & sel_any;
                        state        <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (!wb_cyc_i) begin
                        sram_ce_n_o  <= 1'b1;
                        sram_oe_n_o  <= 1'b1;
                        sram_we_n_o  <= 1'b1;
                        sram_bhe_n_o <= 1'b1;
                        sram_ble_n_o <= 1'b1;
                        sram_dq_oe_o <= 1'b0;
                        state        <= ST_IDLE;
                    end else begin
                        wait_cnt    <= WAIT_LOAD;
                        sram_we_n_o <= ~(we_r & sel_any_r);
                        state       <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    if (!wb_cyc_i) begin
                        sram_ce_n_o  <= 1'b1;
                        sram_oe_n_o  <= 1'b1;
                        sram_we_n_o  <= 1'b1;
                        sram_bhe_n_o <= 1'b1;
                        sram_ble_n_o <= 1'b1;
                        sram_dq_oe_o <= 1'b0;
                        state        <= ST_IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        // Read data is captured on the same edge that closes
                        // the strobes, while oe_n is still low.
                        if (!we_r && sel_any_r) begin
                            wb_dat_o <= sram_dat_i;
                        end
                        wb_ack_o    <= 1'b1;
                        sram_ce_n_o <= 1'b1;
                        sram_oe_n_o <= 1'b1;
                        sram_we_n_o <= 1'b1;
                        state       <= ST_ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                ST_ACK: begin
                    // dq_oe, address and data stayed put through ACK to give
                    // the SRAM its data hold time after we_n rose.
                    wb_ack_o     <= 1'b0;
                    sram_dq_oe_o <= 1'b0;
                    sram_bhe_n_o <= 1'b1;
                    sram_ble_n_o <= 1'b1;
                    state        <= ST_HOLD;
                end

                ST_HOLD: begin
                    // A master that keeps stb high after the ack must not
                    // start a second access.
                    if (!wb_stb_i) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    wb_ack_o     <= 1'b0;
                    sram_ce_n_o  <= 1'b1;
                    sram_oe_n_o  <= 1'b1;
                    sram_we_n_o  <= 1'b1;
                    sram_bhe_n_o <= 1'b1;
                    sram_ble_n_o <= 1'b1;
                    sram_dq_oe_o <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
